serial_ripple_borrow_subtractor: RTL and testbench
==================================================

// Module: serial_ripple_borrow_subtractor
// PURPOSE
//  Bit-serial counterpart of the team's N-bit ripple-carry adder: computes
//  diff = a - b - borrow_in one bit per clock, LSB first, through a single
//  full-subtractor cell and a borrow flip-flop.
//  Trades N cycles of latency for one subtractor cell.
//  Sits behind a valid/ready input and a valid/ready output, so it can drop
//  into a datapath wherever the combinational subtractor is too large.
// PARAMETERS
//  N   8   operand/result width in bits (N >= 1)
// PORTS
//  clk         in   1   rising-edge clock, the only clock
//  rst_n       in   1   asynchronous, active-low reset
//  in_valid    in   1   operands present on a, b, borrow_in
//  in_ready    out  1   block can accept operands
//  a           in   N   minuend (unsigned or two's complement)
//  b           in   N   subtrahend
//  borrow_in   in   1   borrow into bit 0
//  out_valid   out  1   result present on diff, borrow_out, overflow
//  out_ready   in   1   consumer takes the result
//  diff        out  N   a - b - borrow_in, modulo 2^N
//  borrow_out  out  1   borrow out of bit N-1 (unsigned a < b + borrow_in)
//  overflow    out  1   signed overflow: borrow into MSB XOR borrow out of MSB
// BEHAVIOUR
//  - Reset (rst_n low, async):
//    - state=IDLE, bit counter=0, borrow FF=0.
//    - out_valid=0, diff=0, borrow_out=0, overflow=0.
//    - in_ready=1; in_valid is ignored while rst_n is low.
//  - FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE), combinational
//    from the state register.
//  - IDLE, on in_valid at an edge:
//    - a, b go into shift registers; borrow_in goes into the borrow FF.
//    - counter=0, state goes to RUN.
//  - RUN, every edge for bit i=counter:
//    - d_i = a_i ^ b_i ^ br.
//    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br).
//    - d_i shifts into the MSB of the diff shift register (LSB-first fill).
//    - The borrow into bit N-1 is latched for overflow.
//    - counter increments.
//  - End of RUN: at the edge that processes bit N-1, the final diff,
//    borrow_out and overflow are registered and state goes to DONE.
//  - DONE:
//    - out_valid=1; diff, borrow_out and overflow are held stable.
//    - On out_ready at an edge: out_valid clears and state returns to IDLE.
//  - Latency and throughput:
//    - Operands accepted at edge T give out_valid=1 after edge T+N.
//    - Minimum spacing between accepts is N+2 cycles.
//  - While busy: in_valid during RUN/DONE is ignored (in_ready=0) and the
//    captured operands are unaffected.
//  - Simultaneous events: out_ready and in_valid high together in DONE
//    returns the FSM to IDLE only. The new operands are accepted on the
//    following edge if still valid.
//  - out_ready in IDLE or RUN has no effect.
//  - Reset mid-RUN or mid-DONE: the in-flight result is discarded and every
//    register returns to its reset value immediately.
//  - Widths:
//    - Counter is $clog2(N)+1 bits.
//    - Results are modulo 2^N; no saturation.
//    - N=1 must work: exactly one RUN cycle.
// TESTING (N=8 unless stated)
//  1. a=8'h5A, b=8'h3C, bin=0 -> diff=8'h1E, borrow_out=0, overflow=0;
//     out_valid rises exactly 8 cycles after the accept edge.
//  2. a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, borrow_out=1, overflow=0.
//  3. a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, borrow_out=0, overflow=1.
//  4. a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, borrow_out=0, overflow=0.
//  5. Backpressure: out_ready held low 5 cycles in DONE -> outputs stable,
//     in_ready=0. A different in_valid pulse during RUN is ignored and
//     the result still matches the first operands.
//  6. rst_n pulsed low at RUN bit 3 -> out_valid=0, diff=0, in_ready=1
//     immediately. The next op 8'hFF-8'hFF gives diff=8'h00, borrow_out=0.
//  Also: 1000 random ops vs reference model {borrow,diff}=a-b-bin with
//  random out_ready; N=1 sweep of all 8 input combinations.

Source files
------------

// File: rtl/serial_ripple_borrow_subtractor.sv
// serial_ripple_borrow_subtractor
//   Bit-serial subtractor. It computes diff = a - b - borrow_in one bit per
//   clock, LSB first, using a single full-subtractor cell and a borrow
//   flip-flop. A valid/ready handshake sits on each side.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands present on a, b, borrow_in
//   in_ready   out  block is idle and can accept operands
//   a          in   [N-1:0] minuend
//   b          in   [N-1:0] subtrahend
//   borrow_in  in   borrow into bit 0
//   out_valid  out  result present on diff, borrow_out, overflow
//   out_ready  in   consumer takes the result
//   diff       out  [N-1:0] a - b - borrow_in, modulo 2^N
//   borrow_out out  borrow out of bit N-1
//   overflow   out  signed overflow (borrow into MSB xor borrow out of MSB)
module serial_ripple_borrow_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         borrow_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow_out,
  output logic         overflow
);

  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     aShift_q, aShift_d;
  logic [N-1:0]     bShift_q, bShift_d;
  logic [N-1:0]     dShift_q, dShift_d;
  logic [N-1:0]     diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrowOut_q, borrowOut_d;
  logic             overflow_q, overflow_d;

  logic             aBit;
  logic             bBit;
  logic             dBit;
  logic             brNext;
  logic             lastBit;
  logic [N-1:0]     dShiftNext;

  // The single full-subtractor cell. The operand shift registers move right,
  // so bit 0 always holds the bit currently being processed.
  always_comb begin
    aBit       = aShift_q[0];
    bBit       = bShift_q[0];
    dBit       = aBit ^ bBit ^ br_q;
    brNext     = (~aBit & bBit) | (~(aBit ^ bBit) & br_q);
    lastBit    = (cnt_q == CNT_W'(N - 1));
    // New difference bits enter at the MSB. After N shifts the first bit has
    // reached position 0. This form avoids a zero-width slice when N=1.
    dShiftNext = (dShift_q >> 1) | (N'(dBit) << (N - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A simultaneous out_ready and in_valid in DONE only
  // returns to IDLE. The new operands are taken on a later edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (lastBit)   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state register
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next-state. The result registers load only on the edge that
  // processes the last bit, so diff/borrow_out/overflow do not change during
  // RUN. They stay stable through DONE.
  always_comb begin
    cnt_d       = cnt_q;
    aShift_d    = aShift_q;
    bShift_d    = bShift_q;
    dShift_d    = dShift_q;
    diff_d      = diff_q;
    br_d        = br_q;
    borrowOut_d = borrowOut_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          aShift_d = a;
          bShift_d = b;
          br_d     = borrow_in;
          cnt_d    = '0;
        end
      end
      RUN: begin
        aShift_d = aShift_q >> 1;
        bShift_d = bShift_q >> 1;
        dShift_d = dShiftNext;
        br_d     = brNext;
        cnt_d    = cnt_q + CNT_W'(1);
        if (lastBit) begin
          // At the last bit, br_q is the borrow into the MSB.
          diff_d      = dShiftNext;
          borrowOut_d = brNext;
          overflow_d  = br_q ^ brNext;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      aShift_q    <= '0;
      bShift_q    <= '0;
      dShift_q    <= '0;
      diff_q      <= '0;
      br_q        <= 1'b0;
      borrowOut_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      aShift_q    <= aShift_d;
      bShift_q    <= bShift_d;
      dShift_q    <= dShift_d;
      diff_q      <= diff_d;
      br_q        <= br_d;
      borrowOut_q <= borrowOut_d;
      overflow_q  <= overflow_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrowOut_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// tb_serial_ripple_borrow_subtractor
//   Directed and random checks of the bit-serial subtractor.
//   The N=8 instance checks arithmetic, latency, backpressure, busy and
//   simultaneous handshakes, and reset. A second instance with N=1 is swept
//   over all eight input combinations.
module tb_serial_ripple_borrow_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid, inReady, borrowIn, outValid, outReady, borrowOut, overflow;
  logic [7:0] a, b, diff;

  logic       sInValid, sInReady, sBorrowIn, sOutValid, sOutReady, sBorrowOut, sOverflow;
  logic [0:0] sA, sB, sDiff;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  serial_ripple_borrow_subtractor #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid), .in_ready(inReady),
    .a(a), .b(b), .borrow_in(borrowIn),
    .out_valid(outValid), .out_ready(outReady),
    .diff(diff), .borrow_out(borrowOut), .overflow(overflow)
  );

  serial_ripple_borrow_subtractor #(.N(1)) dutN1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sInValid), .in_ready(sInReady),
    .a(sA), .b(sB), .borrow_in(sBorrowIn),
    .out_valid(sOutValid), .out_ready(sOutReady),
    .diff(sDiff), .borrow_out(sBorrowOut), .overflow(sOverflow)
  );

  // Present operands for one accept edge. The task returns 1ns after that edge.
  task automatic startOp(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    @(negedge clk);
    a = ta; b = tb; borrowIn = tbin; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  // Count edges until out_valid. The wait is bounded, so a hung DUT shows up
  // as a wrong count.
  task automatic waitDone(output int cyc);
    cyc = 0;
    while (!outValid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic releaseResult();
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inValid = 1'b1; a = 8'hF0; b = 8'h0F; borrowIn = 1'b1; outReady = 1'b0;
    sInValid = 1'b1; sA = 1'b1; sB = 1'b0; sBorrowIn = 1'b0; sOutReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if ({inReady, outValid, diff, borrowOut, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_state got rdy=%b vld=%b diff=%h bo=%b ov=%b want 1 0 00 0 0",
               inReady, outValid, diff, borrowOut, overflow);
    end
    testsRun++;
    if ({sInReady, sOutValid, sDiff} !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL reset_state_n1 got rdy=%b vld=%b diff=%b want 1 0 0", sInReady, sOutValid, sDiff);
    end
    @(negedge clk);
    inValid = 1'b0; sInValid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    testsRun++;
    if (inReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_idle got in_ready=%b want 1", inReady);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va  [4] = '{8'h5A, 8'h00, 8'h80, 8'h10};
    logic [7:0] vb  [4] = '{8'h3C, 8'h01, 8'h01, 8'h0F};
    logic       vbi [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] ed  [4] = '{8'h1E, 8'hFF, 8'h7F, 8'h00};
    logic       ebo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       eov [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      startOp(va[i], vb[i], vbi[i]);
      waitDone(cyc);
      testsRun++;
      if (cyc !== 8) begin
        testsFailed++;
        $display("[TB] FAIL vec%0d_latency got %0d cycles want 8", i, cyc);
      end
      testsRun++;
      if ({diff, borrowOut, overflow} !== {ed[i], ebo[i], eov[i]}) begin
        testsFailed++;
        $display("[TB] FAIL vec%0d_result got diff=%h bo=%b ov=%b want diff=%h bo=%b ov=%b",
                 i, diff, borrowOut, overflow, ed[i], ebo[i], eov[i]);
      end
      releaseResult();
      testsRun++;
      if ({outValid, inReady} !== 2'b01) begin
        testsFailed++;
        $display("[TB] FAIL vec%0d_release got vld=%b rdy=%b want 0 1", i, outValid, inReady);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    // C3 - 5A = 69. Signed, -61 - 90 = -151, which overflows.
    startOp(8'hC3, 8'h5A, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a = 8'h01; b = 8'h02; borrowIn = 1'b1; inValid = 1'b1;
    testsRun++;
    if (inReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL busy_in_ready got %b want 0", inReady);
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    waitDone(cyc);
    testsRun++;
    if (cyc !== 5) begin
      testsFailed++;
      $display("[TB] FAIL busy_latency got %0d remaining cycles want 5", cyc);
    end
    testsRun++;
    if ({diff, borrowOut, overflow} !== {8'h69, 1'b0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL busy_result got diff=%h bo=%b ov=%b want 69 0 1", diff, borrowOut, overflow);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      testsRun++;
      if ({outValid, inReady, diff, borrowOut, overflow} !== {1'b1, 1'b0, 8'h69, 1'b0, 1'b1}) begin
        testsFailed++;
        $display("[TB] FAIL hold%0d got vld=%b rdy=%b diff=%h bo=%b ov=%b want 1 0 69 0 1",
                 k, outValid, inReady, diff, borrowOut, overflow);
      end
    end
    releaseResult();
  endtask

  task automatic test_simultaneous();
    int cyc;
    startOp(8'h20, 8'h01, 1'b0);
    waitDone(cyc);
    testsRun++;
    if (diff !== 8'h1F) begin
      testsFailed++;
      $display("[TB] FAIL simul_first got diff=%h want 1F", diff);
    end
    @(negedge clk);
    outReady = 1'b1; inValid = 1'b1; a = 8'h33; b = 8'h11; borrowIn = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    testsRun++;
    if ({outValid, inReady} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL simul_to_idle got vld=%b rdy=%b want 0 1", outValid, inReady);
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    testsRun++;
    if (inReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL simul_accept got in_ready=%b want 0", inReady);
    end
    waitDone(cyc);
    testsRun++;
    if ({cyc == 8, diff, borrowOut, overflow} !== {1'b1, 8'h21, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL simul_second got cyc=%0d diff=%h bo=%b ov=%b want 8 21 0 0",
               cyc, diff, borrowOut, overflow);
    end
    releaseResult();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    startOp(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if ({outValid, inReady, diff, borrowOut, overflow} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset got vld=%b rdy=%b diff=%h bo=%b ov=%b want 0 1 00 0 0",
               outValid, inReady, diff, borrowOut, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    testsRun++;
    if ({outValid, inReady} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL midrun_discard got vld=%b rdy=%b want 0 1", outValid, inReady);
    end
    startOp(8'hFF, 8'hFF, 1'b0);
    waitDone(cyc);
    testsRun++;
    if ({cyc == 8, diff, borrowOut, overflow} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      testsFailed++;
      $display("[TB] FAIL after_reset_op got cyc=%0d diff=%h bo=%b ov=%b want 8 00 0 0",
               cyc, diff, borrowOut, overflow);
    end
    releaseResult();
  endtask

  task automatic test_random();
    int cyc, r, s;
    logic [7:0] ra, rb, expD;
    logic rbin, expBo, expOv;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom());
      rb = 8'($urandom());
      rbin = 1'($urandom());
      r = int'(ra) - int'(rb) - int'(rbin);
      s = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
      expD  = r[7:0];
      expBo = (r < 0);
      expOv = (s < -128) || (s > 127);
      startOp(ra, rb, rbin);
      waitDone(cyc);
      testsRun++;
      if ({cyc == 8, diff, borrowOut, overflow} !== {1'b1, expD, expBo, expOv}) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d a=%h b=%h bin=%b got cyc=%0d diff=%h bo=%b ov=%b want 8 %h %b %b",
                 i, ra, rb, rbin, cyc, diff, borrowOut, overflow, expD, expBo, expOv);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      releaseResult();
    end
  endtask

  task automatic test_n1();
    int cyc, r, s;
    logic ta, tb, tbin, expD, expBo, expOv;
    for (int i = 0; i < 8; i++) begin
      ta = i[2]; tb = i[1]; tbin = i[0];
      r = int'(ta) - int'(tb) - int'(tbin);
      // With one bit, a set bit is the value -1 when read as signed.
      s = -int'(ta) + int'(tb) - int'(tbin);
      expD  = r[0];
      expBo = (r < 0);
      expOv = (s < -1) || (s > 0);
      @(negedge clk);
      sA = ta; sB = tb; sBorrowIn = tbin; sInValid = 1'b1;
      @(posedge clk); #1;
      sInValid = 1'b0;
      cyc = 0;
      while (!sOutValid && cyc < 10) begin
        @(posedge clk); #1;
        cyc++;
      end
      testsRun++;
      if ({cyc == 1, sDiff, sBorrowOut, sOverflow} !== {1'b1, expD, expBo, expOv}) begin
        testsFailed++;
        $display("[TB] FAIL n1_%0d a=%b b=%b bin=%b got cyc=%0d d=%b bo=%b ov=%b want 1 %b %b %b",
                 i, ta, tb, tbin, cyc, sDiff, sBorrowOut, sOverflow, expD, expBo, expOv);
      end
      @(negedge clk);
      sOutReady = 1'b1;
      @(posedge clk); #1;
      sOutReady = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_run();
    test_n1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
